// File: rtl/multicycle_control_fetch.sv
// Multicycle fetch/control unit for the accumulator ISA.
// Owns the PC and instruction register, sequences FETCH/DECODE/EXEC/MEM/WB
// against one synchronous memory port and drives the datapath control strobes.
module multicycle_control_fetch #(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    ADDR_WIDTH   = 10,
    parameter int                    OPCODE_WIDTH = 6,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  zero,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  ALUSrc,
    output logic                  MemtoReg,
    output logic                  RegDst,
    output logic                  RegWrite,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  Branch,
    output logic                  halted,
    output logic                  instr_done
);

    localparam int IMM_W = DATA_WIDTH - OPCODE_WIDTH;
    // Common width for extending the operand before cutting it to an address.
    localparam int EXT_W = (IMM_W > ADDR_WIDTH) ? IMM_W : ADDR_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(6'h01);
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(6'h02);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'h03);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQZ  = OPCODE_WIDTH'(6'h04);
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(6'h3F);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    // Set while DECODE is stalled: the word on mem_rdata is then treated as
    // stale and the instruction is fetched again once the stall clears.
    logic                    refetch_q, refetch_d;

    logic [OPCODE_WIDTH-1:0] opcode;
    logic [IMM_W-1:0]        operand;
    logic [EXT_W-1:0]        operand_zext;
    logic [EXT_W-1:0]        operand_sext;
    logic [ADDR_WIDTH-1:0]   operand_addr;
    logic [ADDR_WIDTH-1:0]   branch_off;
    logic [ADDR_WIDTH-1:0]   pc_inc;
    logic [ADDR_WIDTH-1:0]   pc_branch;
    logic                    is_load, is_store, is_addi, is_beqz, is_halt;

    assign opcode       = instr_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign operand      = instr_q[IMM_W-1:0];
    assign operand_zext = EXT_W'(operand);
    assign operand_sext = EXT_W'($signed(operand));
    assign operand_addr = operand_zext[ADDR_WIDTH-1:0];
    assign branch_off   = operand_sext[ADDR_WIDTH-1:0];

    // PC arithmetic wraps modulo 2^ADDR_WIDTH by construction.
    assign pc_inc    = pc_q + ADDR_WIDTH'(1);
    assign pc_branch = pc_inc + branch_off;

    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_beqz  = (opcode == OP_BEQZ);
    assign is_halt  = (opcode == OP_HALT);

    assign pc     = pc_q;
    assign instr  = instr_q;
    // The accumulator is always the destination register.
    assign RegDst = 1'b0;

    // Next-state, PC/IR update and control strobe decode.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a value unassigned, which would infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        refetch_d  = refetch_q;
        mem_addr   = pc_q;
        mem_we     = 1'b0;
        ALUSrc     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Branch     = 1'b0;
        halted     = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (!stall) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                if (stall) begin
                    refetch_d = 1'b1;
                end else if (refetch_q) begin
                    refetch_d = 1'b0;
                    state_d   = S_FETCH;
                end else begin
                    instr_d = mem_rdata;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (is_addi) begin
                    ALUSrc   = 1'b1;
                    RegWrite = 1'b1;
                end
                if (is_beqz) begin
                    Branch = 1'b1;
                end
                if (!stall) begin
                    if (is_load || is_store) begin
                        state_d = S_MEM;
                    end else if (is_halt) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d       = (is_beqz && zero) ? pc_branch : pc_inc;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end

            S_MEM: begin
                mem_addr = operand_addr;
                if (is_load) begin
                    MemRead = 1'b1;
                    if (!stall) begin
                        state_d = S_WB;
                    end
                end else begin
                    MemWrite = 1'b1;
                    if (!stall) begin
                        mem_we     = 1'b1;
                        pc_d       = pc_inc;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end

            S_WB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                if (!stall) begin
                    pc_d       = pc_inc;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State, PC, IR and refetch flag registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (!reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            refetch_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            refetch_q <= refetch_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fetch.sv
// Self-checking bench for multicycle_control_fetch with a synchronous memory
// model and a scoreboard of expected instruction completions and writes.
module tb_multicycle_control_fetch;

    localparam logic [6:0] ST_ALUSRC   = 7'b1000000;
    localparam logic [6:0] ST_MEMTOREG = 7'b0100000;
    localparam logic [6:0] ST_REGWRITE = 7'b0001000;
    localparam logic [6:0] ST_MEMREAD  = 7'b0000100;
    localparam logic [6:0] ST_MEMWRITE = 7'b0000010;
    localparam logic [6:0] ST_BRANCH   = 7'b0000001;

    logic        clk = 1'b0;
    logic        reset, stall, zero;
    logic [15:0] mem_rdata;
    logic [9:0]  mem_addr, pc;
    logic        mem_we;
    logic [15:0] instr;
    logic        ALUSrc, MemtoReg, RegDst, RegWrite, MemRead, MemWrite, Branch;
    logic        halted, instr_done;
    logic [6:0]  strb;

    assign strb = {ALUSrc, MemtoReg, RegDst, RegWrite, MemRead, MemWrite, Branch};

    multicycle_control_fetch #(
        .DATA_WIDTH(16), .ADDR_WIDTH(10), .OPCODE_WIDTH(6), .RESET_PC(10'h000)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .zero(zero),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .pc(pc), .instr(instr),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .Branch(Branch), .halted(halted), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    // Synchronous read memory: data appears one cycle after the address.
    logic [15:0] mem [0:1023];
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    typedef struct {
        int         cycles;   // 0 means cycle count not checked
        logic [9:0] pc_after;
    } done_t;

    done_t      done_q[$];
    logic [9:0] wr_q[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic       pc_pend = 1'b0;
    logic [9:0] pc_pend_val;
    logic [9:0] model_pc;

    // Advance to the next falling edge and run the scoreboard there.
    task automatic step();
        done_t      d;
        logic [9:0] a;
        @(negedge clk);
        if (!reset) begin
            cyc     = 0;
            pc_pend = 1'b0;
            return;
        end
        if (pc_pend) begin
            total++;
            if (pc !== pc_pend_val) begin
                bad++;
                $display("FAIL sb_pc_after: got %h want %h", pc, pc_pend_val);
            end
            pc_pend = 1'b0;
        end
        cyc++;
        if (mem_we === 1'b1) begin
            total++;
            if (wr_q.size() == 0) begin
                bad++;
                $display("FAIL sb_write: got unexpected write addr %h want none", mem_addr);
            end else begin
                a = wr_q.pop_front();
                if (mem_addr !== a) begin
                    bad++;
                    $display("FAIL sb_write_addr: got %h want %h", mem_addr, a);
                end
            end
        end
        if (instr_done === 1'b1) begin
            total++;
            if (done_q.size() == 0) begin
                bad++;
                $display("FAIL sb_done: got unexpected instr_done at pc %h want none", pc);
            end else begin
                d = done_q.pop_front();
                if (d.cycles != 0 && cyc != d.cycles) begin
                    bad++;
                    $display("FAIL sb_cycles: got %0d want %0d", cyc, d.cycles);
                end
                pc_pend     = 1'b1;
                pc_pend_val = d.pc_after;
            end
            cyc = 0;
        end
    endtask

    task automatic drive_after_posedge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        stall = 1'b0;
        zero  = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0C05;
        mem[1] = 16'h0464;
        mem[2] = 16'h0BFF;
        mem[3] = 16'h13FE;
        step();
        step();
        total++;
        if (pc !== 10'h000 || instr !== 16'h0000 || mem_addr !== 10'h000) begin
            bad++;
            $display("FAIL reset_regs: got pc=%h instr=%h addr=%h want 000/0000/000", pc, instr, mem_addr);
        end
        total++;
        if (strb !== 7'b0 || mem_we !== 1'b0 || halted !== 1'b0 || instr_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_outs: got strb=%b we=%b halt=%b done=%b want all 0", strb, mem_we, halted, instr_done);
        end
        drive_after_posedge();
        reset = 1'b1;
        model_pc = 10'h000;
        step();  // FETCH of the first instruction
    endtask

    // Three-cycle instruction (NOP/ADDI/BEQZ/unknown) starting from FETCH.
    task automatic test_exec(input string name, input logic [15:0] word, input logic z,
                             input logic [6:0] exp_strb, input logic [9:0] exp_pc);
        mem[model_pc] = word;
        zero = z;
        done_q.push_back('{3, exp_pc});
        step();  // DECODE
        step();  // EXEC
        total++;
        if (strb !== exp_strb || instr !== word || instr_done !== 1'b1) begin
            bad++;
            $display("FAIL %s_exec: got strb=%b instr=%h done=%b want %b/%h/1", name, strb, instr, instr_done, exp_strb, word);
        end
        step();  // FETCH of next
        total++;
        if (pc !== exp_pc || mem_addr !== exp_pc) begin
            bad++;
            $display("FAIL %s_pc: got pc=%h addr=%h want %h", name, pc, mem_addr, exp_pc);
        end
        model_pc = exp_pc;
        zero = 1'b0;
    endtask

    task automatic test_load();
        mem[model_pc] = 16'h0464;
        done_q.push_back('{5, model_pc + 10'd1});
        step();  // DECODE
        step();  // EXEC
        total++;
        if (strb !== 7'b0 || instr_done !== 1'b0) begin
            bad++;
            $display("FAIL load_exec: got strb=%b done=%b want 0/0", strb, instr_done);
        end
        step();  // MEM
        total++;
        if (mem_addr !== 10'h064 || strb !== ST_MEMREAD || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL load_mem: got addr=%h strb=%b we=%b want 064/%b/0", mem_addr, strb, mem_we, ST_MEMREAD);
        end
        step();  // WB
        total++;
        if (strb !== (ST_MEMTOREG | ST_REGWRITE) || instr_done !== 1'b1 || mem_addr !== model_pc) begin
            bad++;
            $display("FAIL load_wb: got strb=%b done=%b addr=%h want %b/1/%h", strb, instr_done, mem_addr, ST_MEMTOREG | ST_REGWRITE, model_pc);
        end
        step();
        model_pc = model_pc + 10'd1;
        total++;
        if (pc !== model_pc) begin
            bad++;
            $display("FAIL load_pc: got %h want %h", pc, model_pc);
        end
    endtask

    task automatic test_store(input int n_stall);
        logic [9:0] start_pc;
        start_pc = model_pc;
        mem[model_pc] = 16'h0BFF;
        done_q.push_back('{4 + n_stall, model_pc + 10'd1});
        wr_q.push_back(10'h3FF);
        step();  // DECODE
        step();  // EXEC
        if (n_stall > 0) begin
            drive_after_posedge();  // now in MEM
            stall = 1'b1;
            for (int i = 0; i < n_stall; i++) begin
                step();
                total++;
                if (mem_we !== 1'b0 || strb !== ST_MEMWRITE || pc !== start_pc || instr_done !== 1'b0) begin
                    bad++;
                    $display("FAIL store_stall: got we=%b strb=%b pc=%h done=%b want 0/%b/%h/0", mem_we, strb, pc, instr_done, ST_MEMWRITE, start_pc);
                end
                drive_after_posedge();
            end
            stall = 1'b0;
        end
        step();  // MEM, unstalled
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 10'h3FF || strb !== ST_MEMWRITE || instr_done !== 1'b1) begin
            bad++;
            $display("FAIL store_mem: got we=%b addr=%h strb=%b done=%b want 1/3ff/%b/1", mem_we, mem_addr, strb, instr_done, ST_MEMWRITE);
        end
        step();
        model_pc = start_pc + 10'd1;
        total++;
        if (pc !== model_pc || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL store_pc: got pc=%h we=%b want %h/0", pc, mem_we, model_pc);
        end
    endtask

    task automatic test_decode_stall();
        logic [15:0] prev_instr;
        bit          seen;
        prev_instr = instr;
        mem[model_pc] = 16'h0C01;
        done_q.push_back('{0, model_pc + 10'd1});
        drive_after_posedge();  // now in DECODE
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (instr !== prev_instr || pc !== model_pc || strb !== 7'b0 || instr_done !== 1'b0) begin
                bad++;
                $display("FAIL decode_stall_hold: got instr=%h pc=%h strb=%b done=%b want %h/%h/0/0", instr, pc, strb, instr_done, prev_instr, model_pc);
            end
            drive_after_posedge();
        end
        stall = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (instr_done === 1'b1) begin
                seen = 1'b1;
                total++;
                if (strb !== (ST_ALUSRC | ST_REGWRITE) || instr !== 16'h0C01) begin
                    bad++;
                    $display("FAIL decode_stall_exec: got strb=%b instr=%h want %b/0c01", strb, instr, ST_ALUSRC | ST_REGWRITE);
                end
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL decode_stall_timeout: got no instr_done want one within 12 cycles");
        end
        step();
        model_pc = model_pc + 10'd1;
        total++;
        if (pc !== model_pc) begin
            bad++;
            $display("FAIL decode_stall_pc: got %h want %h", pc, model_pc);
        end
    endtask

    task automatic test_halt();
        logic [9:0] hpc;
        hpc = model_pc;
        mem[model_pc] = 16'hFC00;
        step();  // DECODE
        step();  // EXEC
        total++;
        if (strb !== 7'b0 || instr_done !== 1'b0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL halt_exec: got strb=%b done=%b halted=%b want 0/0/0", strb, instr_done, halted);
        end
        for (int i = 0; i < 20; i++) begin
            drive_after_posedge();
            stall = 1'($urandom_range(0, 1));
            step();
            total++;
            if (halted !== 1'b1 || pc !== hpc || strb !== 7'b0 || mem_we !== 1'b0 || instr_done !== 1'b0) begin
                bad++;
                $display("FAIL halt_hold: got halted=%b pc=%h strb=%b we=%b done=%b want 1/%h/0/0/0", halted, pc, strb, mem_we, instr_done, hpc);
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        drive_after_posedge();
        reset = 1'b0;
        step();
        mem[0] = 16'h0000;
        mem[1] = 16'h0464;
        drive_after_posedge();
        reset = 1'b1;
        model_pc = 10'h000;
        step();  // FETCH at 0
        test_exec("nop0", 16'h0000, 1'b0, 7'b0, 10'h001);
        step();  // DECODE of LOAD
        step();  // EXEC
        step();  // MEM
        total++;
        if (strb !== ST_MEMREAD || pc !== 10'h001) begin
            bad++;
            $display("FAIL abort_pre: got strb=%b pc=%h want %b/001", strb, pc, ST_MEMREAD);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if (pc !== 10'h000 || instr !== 16'h0000 || mem_addr !== 10'h000 || strb !== 7'b0 ||
            mem_we !== 1'b0 || halted !== 1'b0 || instr_done !== 1'b0) begin
            bad++;
            $display("FAIL abort_reset: got pc=%h instr=%h addr=%h strb=%b we=%b halt=%b done=%b want all 0", pc, instr, mem_addr, strb, mem_we, halted, instr_done);
        end
        step();
        drive_after_posedge();
        reset = 1'b1;
        model_pc = 10'h000;
        step();
        test_exec("nop_after_abort", 16'h0000, 1'b0, 7'b0, 10'h001);
    endtask

    initial begin
        test_reset();
        test_exec("addi", 16'h0C05, 1'b0, ST_ALUSRC | ST_REGWRITE, 10'h001);
        test_load();
        test_store(0);
        test_exec("beqz_taken", 16'h13FE, 1'b1, ST_BRANCH, 10'h002);
        test_store(4);
        test_exec("beqz_not_taken", 16'h13FE, 1'b0, ST_BRANCH, 10'h004);
        test_decode_stall();
        test_exec("beqz_back_wrap", 16'h13F8, 1'b1, ST_BRANCH, 10'h3FE);
        test_exec("beqz_fwd_wrap", 16'h1001, 1'b1, ST_BRANCH, 10'h000);
        test_exec("unknown_op", 16'hA800, 1'b0, 7'b0, 10'h001);
        test_halt();
        test_reset_mid_load();
        total++;
        if (done_q.size() != 0 || wr_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got done_q=%0d wr_q=%0d pending want 0/0", done_q.size(), wr_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fetch.md
Name: multicycle_control_fetch

Overview:
- Parametrised successor to the single-cycle memory-plus-control pairing.
- Owns the PC and instruction register, and drives instruction and data accesses to one external synchronous memory port.
- Runs a multicycle FETCH/DECODE/EXEC/MEM/WB state machine for the accumulator ISA and emits the seven datapath control strobes.
- Adds a stall handshake, branch resolution, HALT, and generic data/address/opcode widths.

Parameters:
- DATA_WIDTH, 16: instruction and data word width.
- ADDR_WIDTH, 10: PC and memory address width.
- OPCODE_WIDTH, 6: opcode field, instr[DATA_WIDTH-1 -: OPCODE_WIDTH]; operand is the remaining low bits (IMM_W = DATA_WIDTH-OPCODE_WIDTH).
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; low clears all state.
- stall  in  1  high freezes the FSM, PC and IR.
- zero  in  1  accumulator==0 flag from the datapath, sampled in EXEC.
- mem_rdata  in  DATA_WIDTH  synchronous memory read data, valid one cycle after the address.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_we  out  1  memory write enable.
- pc  out  ADDR_WIDTH  current PC.
- instr  out  DATA_WIDTH  instruction register.
- ALUSrc, MemtoReg, RegDst, RegWrite, MemRead, MemWrite, Branch  out  1 each  control strobes.
- halted  out  1  high in HALT state.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH, pc=RESET_PC, instr=0.
  - All strobes, mem_we, halted and instr_done are 0.
  - Reset mid-instruction aborts it with no memory write.
- Opcodes:
  - 0x00 NOP.
  - 0x01 LOAD: acc=M[op].
  - 0x02 STORE: M[op]=acc.
  - 0x03 ADDI: acc+=sext(op).
  - 0x04 BEQZ.
  - 0x3F HALT.
  - Any other opcode executes as NOP.
  - Opcode values are zero-extended if OPCODE_WIDTH>6.
- Address field: op is truncated or zero-extended to ADDR_WIDTH for memory addresses and sign-extended for the branch offset.
- FETCH:
  - mem_addr=pc, MemRead=0.
  - Next state DECODE.
- DECODE:
  - instr<=mem_rdata.
  - Next state EXEC.
- EXEC: strobes are decoded from instr, valid this cycle only.
  - ADDI: ALUSrc=1, RegWrite=1.
  - BEQZ: Branch=1.
  - NOP/ADDI/BEQZ: pc updates, instr_done=1, next state FETCH.
  - LOAD/STORE: next state MEM.
  - HALT: next state HALT.
- PC update:
  - Default: pc<=pc+1.
  - BEQZ with zero=1: pc<=pc+1+sext(op).
  - All PC arithmetic is modulo 2^ADDR_WIDTH; wrap is legal.
- MEM: mem_addr=op.
  - LOAD: MemRead=1, next state WB.
  - STORE: MemWrite=1, mem_we=1, pc<=pc+1, instr_done=1, next state FETCH.
- WB (LOAD only):
  - MemtoReg=1, RegWrite=1, pc<=pc+1, instr_done=1.
  - Next state FETCH.
- HALT:
  - halted=1, pc holds, all strobes are 0.
  - Exit only through reset.
- RegDst: always 0 (accumulator target); the port is kept for datapath compatibility.
- Outside its state, every strobe is 0 and mem_addr=pc.
- stall=1:
  - State, pc and instr hold; mem_we and instr_done are forced to 0; other strobes hold their current decode.
  - In DECODE, instr is not loaded. After stall drops, the FSM re-enters FETCH for the same pc to refetch the word.
  - In HALT, stall has no effect.
- Cycles per instruction with no stalls: NOP/ADDI/BEQZ 3, STORE 4, LOAD 5.

Test Plan:
- Reset then release with M[0]=0x0C05 (ADDI 5) -> EXEC in cycle 3 shows ALUSrc=1 and RegWrite=1, pc becomes 1, instr_done pulses once.
- M[1]=0x0464 (LOAD 0x64) -> MEM shows mem_addr=0x064 and MemRead=1; WB shows MemtoReg=1 and RegWrite=1; 5 cycles total; pc=2.
- STORE 0x3FF at pc=2 -> mem_we=1 for exactly one cycle with mem_addr=0x3FF; pc=3.
- BEQZ offset -2 (0x13FE) at pc=3 with zero=1 -> pc=2. Repeat with zero=0 -> pc=4. BEQZ +1 at pc=0x3FE with zero=1 -> pc wraps to 0x000.
- stall held 4 cycles during a STORE's MEM state -> mem_we stays 0 throughout, one write after release, pc unchanged while stalled. Stall during DECODE -> word refetched, no skipped instruction.
- HALT (0xFC00) -> halted=1 and pc frozen for 20 cycles. Assert reset low mid-LOAD -> immediate pc=RESET_PC with all outputs 0.
